// File: rtl/jtkiwi_tmdraw.sv
// Tile-map row renderer: draws one 16-pixel row of a 16x16 4bpp tile into a
// line buffer. Each tile row is fetched from graphics ROM as two 32-bit words
// (eight pixels per word) and written out one pixel per clock.
//
// ROM handshake: rom_addr is held stable while rom_cs=1. The renderer asserts
// rom_cs on entering FETCH and keeps it high through WAIT. The first cycle
// (FETCH) is the address-change cycle, so rom_ok seen there is not trusted.
// In WAIT, the first cycle with rom_ok=1 transfers rom_data and rom_cs drops on
// the next cycle. There is no timeout: a ROM that never answers stalls the
// renderer in WAIT.
module jtkiwi_tmdraw (
    input  logic        clk,
    input  logic        rst,
    input  logic        draw,
    output logic        busy,
    input  logic [15:0] code,
    input  logic [15:0] attr,
    input  logic [8:0]  xpos,
    input  logic [3:0]  ysub,
    input  logic        flip,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic [8:0]  buf_addr,
    output logic        buf_we,
    output logic [8:0]  buf_din,
    output logic [1:0]  st_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t      state, state_nxt;

    logic [12:0] code_l;
    logic [4:0]  pal_l;
    logic [8:0]  xpos_l;
    logic [3:0]  ysub_l;
    logic        hf, vf;
    logic        half;
    logic [2:0]  cnt;
    logic [31:0] pix_data;
    logic [2:0]  nib_sel;
    logic [3:0]  pixel;

    // Only the tile number and palette fields of code/attr matter here.
    logic unused_bits;
    assign unused_bits = ^{code[13], attr[10:0]};

    // Half select is XORed with hflip so a mirrored tile fetches its right
    // half first; row is mirrored by vflip.
    assign rom_addr = {code_l, ysub_l ^ {4{vf}}, half ^ hf};
    // Screen position always advances left to right; wraps at 512.
    assign buf_addr = xpos_l + {5'd0, half, cnt};
    assign buf_din  = {pal_l, pixel};
    assign st_dbg   = state;

    // Pick the nibble for the current pixel: leftmost first unless mirrored.
    always_comb begin
        nib_sel = hf ? cnt : ~cnt;
        pixel   = pix_data[{nib_sel, 2'b00} +: 4];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and FSM-driven outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        rom_cs    = 1'b0;
        buf_we    = 1'b0;
        case (state)
            IDLE: begin
                if (draw) state_nxt = FETCH;
            end
            FETCH: begin
                rom_cs    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                rom_cs = 1'b1;
                if (rom_ok) state_nxt = DRAW;
            end
            DRAW: begin
                // Pixel value 0 is transparent.
                buf_we = (pixel != 4'd0);
                if (cnt == 3'd7) state_nxt = half ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: request latches, ROM word capture and pixel/half counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_l   <= 13'd0;
            pal_l    <= 5'd0;
            xpos_l   <= 9'd0;
            ysub_l   <= 4'd0;
            hf       <= 1'b0;
            vf       <= 1'b0;
            half     <= 1'b0;
            cnt      <= 3'd0;
            pix_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (draw) begin
                        code_l <= code[12:0];
                        pal_l  <= attr[15:11];
                        xpos_l <= xpos;
                        ysub_l <= ysub;
                        hf     <= code[14] ^ flip;
                        vf     <= code[15] ^ flip;
                        half   <= 1'b0;
                        cnt    <= 3'd0;
                    end
                end
                WAIT: begin
                    if (rom_ok) begin
                        pix_data <= rom_data;
                        cnt      <= 3'd0;
                    end
                end
                DRAW: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) half <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
